multi_pwm_generator: RTL and testbench

Parametrised multi-channel PWM generator, the next generation of the team's single-channel PWM block. A prescaler divides the system clock into a tick and a free-running divided clock output. A shared period counter then drives N independent duty comparators. Each channel has selectable polarity, and the shared counter runs edge-aligned or center-aligned. Period, duty and mode are double-buffered and take effect only at a period boundary, so outputs never glitch. The block feeds motor and LED drivers directly.

---
 rtl/multi_pwm_generator.sv | 169 ++++++++++++++++
 tb/tb_multi_pwm_generator.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_pwm_generator.sv
// multi_pwm_generator
//
// Multi-channel PWM generator. A prescaler produces a tick every PRESCALE
// enabled clocks and a free-running divided clock. A shared period counter,
// edge-aligned or center-aligned, drives CHANNELS duty comparators whose
// registered outputs can be individually inverted. Period, duty and mode are
// double-buffered (shadow -> active) and only switch at a period boundary.
//
// Ports
//   clk_3125KHz   system clock, rising edge
//   reset         asynchronous, active-high; clears all state
//   enable        1 = run, 0 = hold idle (outputs at inactive level)
//   load          one-cycle strobe; captures period/duty_cycle/center
//   period        counter top value P
//   duty_cycle    channel i duty at bits [i*CNT_WIDTH +: CNT_WIDTH]
//   center        0 = edge-aligned, 1 = center-aligned
//   polarity      per-channel output inversion (live)
//   clk_div       divided clock, toggles on every tick
//   period_start  one-clock pulse after each boundary tick
//   pwm_signal    PWM outputs
module multi_pwm_generator #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 8,
  parameter int PRESCALE  = 8
) (
  input  logic                          clk_3125KHz,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          load,
  input  logic [CNT_WIDTH-1:0]          period,
  input  logic [CHANNELS*CNT_WIDTH-1:0] duty_cycle,
  input  logic                          center,
  input  logic [CHANNELS-1:0]           polarity,
  output logic                          clk_div,
  output logic                          period_start,
  output logic [CHANNELS-1:0]           pwm_signal
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  logic [PRE_W-1:0]              pre_cnt;
  logic [CNT_WIDTH-1:0]          cnt;
  dir_t                          dir;

  logic [CNT_WIDTH-1:0]          shadow_period;
  logic [CHANNELS*CNT_WIDTH-1:0] shadow_duty;
  logic                          shadow_center;
  logic [CNT_WIDTH-1:0]          act_period;
  logic [CHANNELS*CNT_WIDTH-1:0] act_duty;
  logic                          act_center;
  logic                          pending;

  logic                          tick;
  logic                          boundary;
  logic                          apply;
  logic [CNT_WIDTH-1:0]          cnt_next;
  dir_t                          dir_next;
  logic [CHANNELS-1:0]           raw;

  assign tick = enable && (pre_cnt == PRE_LAST);

  // Shadow moves to active at a boundary tick, or at once while idle so a
  // load made before enabling is in force from the first period.
  assign apply = pending && (!enable || (tick && boundary));

  // Counter next-state, evaluated for the current tick.
  always_comb begin
    cnt_next = cnt;
    dir_next = dir;
    boundary = 1'b0;
    if (act_period == '0) begin
      cnt_next = '0;
      dir_next = UP;
      boundary = 1'b1;
    end else if (!act_center) begin
      dir_next = UP;
      if (cnt >= act_period) begin
        cnt_next = '0;
        boundary = 1'b1;
      end else begin
        cnt_next = cnt + CNT_ONE;
      end
    end else if (dir == UP) begin
      if (cnt >= act_period) begin
        if (act_period == CNT_ONE) begin
          // P=1: 0,1,0,1 ... with the boundary on the 1 -> 0 step
          cnt_next = '0;
          boundary = 1'b1;
        end else begin
          cnt_next = act_period - CNT_ONE;
          dir_next = DOWN;
        end
      end else begin
        cnt_next = cnt + CNT_ONE;
      end
    end else begin
      if (cnt <= CNT_ONE) begin
        cnt_next = '0;
        dir_next = UP;
        boundary = 1'b1;
      end else begin
        cnt_next = cnt - CNT_ONE;
      end
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      raw[i] = cnt < act_duty[i*CNT_WIDTH +: CNT_WIDTH];
    end
  end

  always_ff @(posedge clk_3125KHz or posedge reset) begin
    if (reset) begin
      pre_cnt       <= '0;
      cnt           <= '0;
      dir           <= UP;
      shadow_period <= '1;
      shadow_duty   <= '0;
      shadow_center <= 1'b0;
      act_period    <= '1;
      act_duty      <= '0;
      act_center    <= 1'b0;
      pending       <= 1'b0;
      clk_div       <= 1'b0;
      period_start  <= 1'b0;
      pwm_signal    <= '0;
    end else begin
      // A load coinciding with an apply keeps pending set: the old shadow is
      // applied now and the new one waits for the next boundary.
      if (load) begin
        shadow_period <= period;
        shadow_duty   <= duty_cycle;
        shadow_center <= center;
      end
      pending <= load || (pending && !apply);
      if (apply) begin
        act_period <= shadow_period;
        act_duty   <= shadow_duty;
        act_center <= shadow_center;
      end

      if (!enable) begin
        pre_cnt      <= '0;
        cnt          <= '0;
        dir          <= UP;
        period_start <= 1'b0;
        pwm_signal   <= polarity;
      end else begin
        pre_cnt      <= tick ? '0 : pre_cnt + PRE_W'(1);
        period_start <= tick && boundary;
        pwm_signal   <= raw ^ polarity;
        if (tick) begin
          // A boundary always yields cnt=0, dir=UP, matching the restart
          // required when new active values are applied.
          cnt     <= cnt_next;
          dir     <= dir_next;
          clk_div <= !clk_div;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_pwm_generator.sv
// tb_multi_pwm_generator
//
// Bench for multi_pwm_generator (CHANNELS=4, CNT_WIDTH=8, PRESCALE=8).
// The stimulus process queues the expected length and per-channel high count
// of each PWM period; a monitor measures the DUT between consecutive
// period_start pulses and compares against the queue head.
module tb_multi_pwm_generator;

  localparam int CH = 4;
  localparam int CW = 8;
  localparam int PS = 8;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             load;
  logic [CW-1:0]    period;
  logic [CH*CW-1:0] duty_cycle;
  logic             center;
  logic [CH-1:0]    polarity;
  logic             clk_div;
  logic             period_start;
  logic [CH-1:0]    pwm_signal;

  multi_pwm_generator #(
    .CHANNELS(CH),
    .CNT_WIDTH(CW),
    .PRESCALE(PS)
  ) dut (
    .clk_3125KHz(clk),
    .reset(reset),
    .enable(enable),
    .load(load),
    .period(period),
    .duty_cycle(duty_cycle),
    .center(center),
    .polarity(polarity),
    .clk_div(clk_div),
    .period_start(period_start),
    .pwm_signal(pwm_signal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [15:0]          len;
    logic [CH-1:0][15:0]  hi;
  } rec_t;

  rec_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   sync_req = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic rec_t mk(input int len, input int h0, input int h1,
                              input int h2, input int h3);
    rec_t r;
    r.len   = 16'(len);
    r.hi[0] = 16'(h0);
    r.hi[1] = 16'(h1);
    r.hi[2] = 16'(h2);
    r.hi[3] = 16'(h3);
    return r;
  endfunction

  task automatic monitor();
    int   sync_seen = 0;
    bit   armed = 1'b0;
    int   len_cnt = 0;
    int   hi [CH];
    rec_t e;
    for (int i = 0; i < CH; i++) hi[i] = 0;
    forever begin
      @(negedge clk);
      if (sync_seen != sync_req) begin
        sync_seen = sync_req;
        armed = 1'b0;
      end
      if (period_start) begin
        if (armed) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_period: got period of %0d clocks, expected none", len_cnt);
          end else begin
            e = exp_q.pop_front();
            check("period_len", len_cnt, int'(e.len));
            for (int i = 0; i < CH; i++)
              check($sformatf("high_ch%0d", i), hi[i], int'(e.hi[i]));
          end
        end
        armed = 1'b1;
        len_cnt = 0;
        for (int i = 0; i < CH; i++) hi[i] = 0;
      end
      len_cnt++;
      for (int i = 0; i < CH; i++) hi[i] += int'(pwm_signal[i]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_duty(input int d0, input int d1, input int d2, input int d3);
    duty_cycle = {CW'(d3), CW'(d2), CW'(d1), CW'(d0)};
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_ps();
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (period_start) break;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_period_start: got no pulse in %0d clocks, expected one", n);
    end
  endtask

  task automatic wait_empty(input int bound);
    for (int n = 0; n < bound; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("queue_consumed", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    int total;
    reset      = 1'b1;
    enable     = 1'b0;
    load       = 1'b0;
    center     = 1'b0;
    period     = '0;
    duty_cycle = '0;
    polarity   = '0;
    fork
      monitor();
    join_none

    // Reset defaults, then idle with enable=0
    step(3);
    check("rst_outputs", int'({clk_div, period_start, pwm_signal}), 0);
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      check("idle_outputs", int'({clk_div, period_start, pwm_signal}), 0);
    end

    // Edge mode basic: P=9, duties 3/10/0/5
    period = 8'd9;
    center = 1'b0;
    set_duty(3, 10, 0, 5);
    pulse_load();
    step(1);
    enable = 1'b1;
    sync_req++;
    repeat (3) exp_q.push_back(mk(80, 24, 80, 0, 40));
    for (n = 0; n < 40 && !clk_div; n++) @(negedge clk);
    n = 0;
    while (clk_div && n < 40) begin @(negedge clk); n++; end
    check("clkdiv_high", n, 8);
    n = 0;
    while (!clk_div && n < 40) begin @(negedge clk); n++; end
    check("clkdiv_low", n, 8);
    wait_empty(600);

    // Polarity is live: ch2 (duty 0) goes high on the next clock
    step(2);
    check("pol_before", int'(pwm_signal[2]), 0);
    polarity = 4'b0100;
    sync_req++;
    @(negedge clk);
    check("pol_next_clk", int'(pwm_signal[2]), 1);
    repeat (2) exp_q.push_back(mk(80, 24, 80, 80, 40));
    wait_empty(400);

    // Glitch-free update: load duty 7 on ch0 while cnt=4
    repeat (2) exp_q.push_back(mk(80, 24, 80, 80, 40));
    repeat (2) exp_q.push_back(mk(80, 56, 80, 80, 40));
    wait_ps();
    step(33);
    set_duty(7, 10, 0, 5);
    pulse_load();
    wait_empty(500);

    // Load on boundary: A (5) mid-period, B (2) on the boundary tick
    repeat (2) exp_q.push_back(mk(80, 56, 80, 80, 40));
    exp_q.push_back(mk(80, 40, 80, 80, 40));
    repeat (2) exp_q.push_back(mk(80, 16, 80, 80, 40));
    wait_ps();
    step(33);
    set_duty(5, 10, 0, 5);
    pulse_load();
    step(45);
    set_duty(2, 10, 0, 5);
    pulse_load();
    wait_empty(700);

    // Center mode: P=4, duties 2/5/0/4
    repeat (2) exp_q.push_back(mk(80, 16, 80, 80, 40));
    exp_q.push_back(mk(64, 23, 64, 64, 55));
    repeat (2) exp_q.push_back(mk(64, 24, 64, 64, 56));
    wait_ps();
    step(10);
    period = 8'd4;
    center = 1'b1;
    set_duty(2, 5, 0, 4);
    pulse_load();
    wait_empty(700);

    // Asynchronous reset mid-period while ch0 is high
    sync_req++;
    wait_ps();
    @(negedge clk);
    check("pre_rst_high", int'(pwm_signal[0]), 1);
    #2 reset = 1'b1;
    #1 check("async_rst_outputs", int'({clk_div, period_start, pwm_signal}), 0);
    polarity = '0;
    sync_req++;
    @(negedge clk);
    reset = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (clk_div) break;
    end
    check("first_tick_after_rst", n, 8);
    total = n;
    while (!period_start && total < 3000) begin
      @(negedge clk);
      total++;
    end
    check("first_boundary_after_rst", total, 2048);
    check("pwm_after_rst", int'(pwm_signal), 0);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
